test_vector_loader: RTL and testbench

//  Upstream feeder for the neural network datapath. Collects one test vector as a

---
 rtl/test_vector_loader_if.sv | 36 +++
 rtl/test_vector_loader.sv | 136 +++++++++++++
 tb/tb_test_vector_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_vector_loader_if.sv
// Bundle of every signal between the test vector loader and its environment:
// the byte stream in, the packed vector and start pulse out to the datapath,
// the class result back, and the held result towards the consumer.
interface test_vector_loader_if #(
  parameter int DW = 8,
  parameter int N  = 62,
  parameter int CW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;

  logic [N*DW-1:0] test_data;
  logic            start;
  logic            nn_ready;
  logic [7:0]      nn_class;

  logic          result_valid;
  logic [7:0]    class_out;
  logic          result_ack;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  // Loader side of the bundle.
  modport slave (
    input  in_valid, in_data, in_last, nn_ready, nn_class, result_ack,
    output in_ready, test_data, start, result_valid, class_out, frame_err, frame_cnt
  );

  // Environment side: byte source, datapath and result consumer.
  modport master (
    output in_valid, in_data, in_last, nn_ready, nn_class, result_ack,
    input  in_ready, test_data, start, result_valid, class_out, frame_err, frame_cnt
  );
endinterface

// File: rtl/test_vector_loader.sv
// Upstream feeder for the neural network datapath. Packs one framed byte
// stream into the flat test_data bus, pulses start, waits for the datapath
// result, and holds the captured class until the consumer acknowledges it.
module test_vector_loader #(
  parameter int DW = 8,
  parameter int N  = 62,
  parameter int CW = 16
) (
  input logic                 clk,
  input logic                 rst,
  test_vector_loader_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N*DW-1:0] test_data_q, test_data_d;
  logic [7:0]      class_q, class_d;
  logic [CW-1:0]   frame_cnt_q, frame_cnt_d;
  logic            start_q, start_d;
  logic            result_valid_q, result_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            in_ready_q, in_ready_d;
  logic            armed_q, armed_d;
  logic            beat;
  logic            drop;

  // Next-state logic: framing checks in FILL, one-cycle issue, guarded wait
  // for the datapath result, then hold until the consumer acknowledges.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    test_data_d = test_data_q;
    class_d     = class_q;
    frame_cnt_d = frame_cnt_q;
    armed_d     = armed_q;
    beat        = 1'b0;
    drop        = 1'b0;

    case (state_q)
      FILL: begin
        beat = bus.in_valid && in_ready_q;
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (bus.in_last) begin
              test_data_d[idx_q*DW +: DW] = bus.in_data;
              state_d = ISSUE;
            end else begin
              drop = 1'b1;
            end
          end else if (bus.in_last) begin
            idx_d = '0;
            drop  = 1'b1;
          end else begin
            test_data_d[idx_q*DW +: DW] = bus.in_data;
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ISSUE: begin
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        // The first WAIT cycle only arms, so a ready left over from the
        // previous vector can never be mistaken for this vector's result.
        if (!armed_q) begin
          armed_d = 1'b1;
        end else if (bus.nn_ready) begin
          class_d     = bus.nn_class;
          frame_cnt_d = frame_cnt_q + 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.result_ack) begin
          state_d = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    start_d        = (state_d == ISSUE);
    result_valid_d = (state_d == HOLD);
    frame_err_d    = drop;
    // Ready drops for the single cycle after a dropped frame so that a run of
    // one-beat frames can never produce a frame_err pulse longer than a cycle.
    in_ready_d     = (state_d == FILL) && !drop;
  end

  // State and output registers, cleared asynchronously while rst is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= FILL;
      idx_q          <= '0;
      test_data_q    <= '0;
      class_q        <= '0;
      frame_cnt_q    <= '0;
      start_q        <= 1'b0;
      result_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
      in_ready_q     <= 1'b0;
      armed_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      test_data_q    <= test_data_d;
      class_q        <= class_d;
      frame_cnt_q    <= frame_cnt_d;
      start_q        <= start_d;
      result_valid_q <= result_valid_d;
      frame_err_q    <= frame_err_d;
      in_ready_q     <= in_ready_d;
      armed_q        <= armed_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.test_data    = test_data_q;
  assign bus.start        = start_q;
  assign bus.result_valid = result_valid_q;
  assign bus.class_out    = class_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_test_vector_loader.sv
// Directed bench for test_vector_loader: nominal frame, short and long
// framing errors, stale-ready guard, result backpressure, asynchronous reset,
// and counter wrap on a small second instance with a 2-bit counter.
module tb_test_vector_loader;
  localparam int DW = 8;
  localparam int N  = 62;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  logic [N*DW-1:0] expData;

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  test_vector_loader_if #(.DW(DW), .N(N), .CW(CW)) bus ();
  test_vector_loader_if #(.DW(8), .N(2), .CW(2))   sbus ();

  test_vector_loader #(.DW(DW), .N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  test_vector_loader #(.DW(8), .N(2), .CW(2)) sdut (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  task automatic checkOutput(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one beat and holds it until the loader has taken it.
  task automatic applyStimulus(input logic [7:0] d, input logic last);
    int guard;
    guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (bus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("beat_accept", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic sendFrame(input int len, input int lastAt, input int base);
    for (int k = 0; k < len; k++) begin
      applyStimulus(8'(base + k), (k == lastAt));
    end
  endtask

  task automatic buildExp(input int base);
    for (int k = 0; k < N; k++) begin
      expData[k*8 +: 8] = 8'(base + k);
    end
  endtask

  // Returns a class while in WAIT, checks the capture, then acknowledges it.
  task automatic finishResult(input logic [7:0] cls, input logic [CW-1:0] expCnt);
    int guard;
    guard = 0;
    bus.nn_ready = 1'b1;
    bus.nn_class = cls;
    while (bus.result_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    bus.nn_ready = 1'b0;
    checkOutput("result_valid_set", bus.result_valid, 1'b1);
    checkOutput("class_out", bus.class_out, cls);
    checkOutput("frame_cnt", bus.frame_cnt, expCnt);
    checkOutput("test_data_stable", bus.test_data, expData);
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    checkOutput("result_valid_clr", bus.result_valid, 1'b0);
    checkOutput("in_ready_after_ack", bus.in_ready, 1'b1);
  endtask

  // One two-beat frame through the small instance, with its counter checked.
  task automatic smallFrame(input logic [7:0] cls, input logic [1:0] expCnt);
    int guard;
    guard = 0;
    sbus.in_valid = 1'b1;
    sbus.in_data  = cls;
    sbus.in_last  = 1'b0;
    while (sbus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("s_beat0", sbus.in_ready, 1'b1);
    @(negedge clk);
    sbus.in_data = cls + 8'd1;
    sbus.in_last = 1'b1;
    guard = 0;
    while (sbus.in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("s_beat1", sbus.in_ready, 1'b1);
    @(negedge clk);
    sbus.in_valid = 1'b0;
    sbus.in_last  = 1'b0;
    checkOutput("s_start", sbus.start, 1'b1);
    checkOutput("s_test_data", sbus.test_data, {cls + 8'd1, cls});
    sbus.nn_ready = 1'b1;
    sbus.nn_class = cls;
    guard = 0;
    while (sbus.result_valid !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    sbus.nn_ready = 1'b0;
    checkOutput("s_class_out", sbus.class_out, cls);
    checkOutput("s_frame_cnt", sbus.frame_cnt, expCnt);
    sbus.result_ack = 1'b1;
    @(negedge clk);
    sbus.result_ack = 1'b0;
  endtask

  // Safety net in case a bounded wait is somehow bypassed.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    rst = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_last = 1'b0;
    bus.nn_ready = 1'b0;  bus.nn_class = '0; bus.result_ack = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_data = '0; sbus.in_last = 1'b0;
    sbus.nn_ready = 1'b0; sbus.nn_class = '0; sbus.result_ack = 1'b0;

    #12;
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_start", bus.start, 1'b0);
    checkOutput("rst_result_valid", bus.result_valid, 1'b0);
    checkOutput("rst_frame_err", bus.frame_err, 1'b0);
    checkOutput("rst_frame_cnt", bus.frame_cnt, '0);
    checkOutput("rst_test_data", bus.test_data, '0);
    checkOutput("rst_class_out", bus.class_out, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_rst", bus.in_ready, 1'b1);

    $display("[TB] T2 nominal frame");
    buildExp(1);
    sendFrame(62, 61, 1);
    checkOutput("t2_start", bus.start, 1'b1);
    checkOutput("t2_test_data", bus.test_data, expData);
    checkOutput("t2_low_byte", bus.test_data[7:0], 8'd1);
    checkOutput("t2_high_byte", bus.test_data[495:488], 8'd62);
    checkOutput("t2_in_ready_issue", bus.in_ready, 1'b0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("t2_start_low", bus.start, 1'b0);
      checkOutput("t2_wait_no_result", bus.result_valid, 1'b0);
    end
    finishResult(8'd3, 16'd1);

    $display("[TB] T3 short frame");
    sendFrame(10, 9, 8'hA0);
    checkOutput("t3_frame_err", bus.frame_err, 1'b1);
    checkOutput("t3_no_start", bus.start, 1'b0);
    @(negedge clk);
    checkOutput("t3_err_pulse_end", bus.frame_err, 1'b0);
    checkOutput("t3_no_start2", bus.start, 1'b0);
    buildExp(100);
    sendFrame(62, 61, 100);
    checkOutput("t3_start", bus.start, 1'b1);
    checkOutput("t3_test_data", bus.test_data, expData);
    finishResult(8'h5A, 16'd2);

    $display("[TB] T4 long frame");
    sendFrame(62, -1, 200);
    checkOutput("t4_frame_err", bus.frame_err, 1'b1);
    checkOutput("t4_no_start", bus.start, 1'b0);
    @(negedge clk);
    checkOutput("t4_err_pulse_end", bus.frame_err, 1'b0);
    checkOutput("t4_no_start2", bus.start, 1'b0);
    checkOutput("t4_in_ready", bus.in_ready, 1'b1);

    $display("[TB] T5 stale ready");
    bus.nn_ready = 1'b1;
    bus.nn_class = 8'd7;
    buildExp(50);
    sendFrame(62, 61, 50);
    checkOutput("t5_start", bus.start, 1'b1);
    checkOutput("t5_test_data", bus.test_data, expData);
    checkOutput("t5_issue_no_result", bus.result_valid, 1'b0);
    @(negedge clk);
    checkOutput("t5_wait1_no_result", bus.result_valid, 1'b0);
    @(negedge clk);
    checkOutput("t5_guard_no_capture", bus.result_valid, 1'b0);
    @(negedge clk);
    bus.nn_ready = 1'b0;
    checkOutput("t5_capture", bus.result_valid, 1'b1);
    checkOutput("t5_class_out", bus.class_out, 8'd7);
    checkOutput("t5_frame_cnt", bus.frame_cnt, 16'd3);

    $display("[TB] T6 result backpressure");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    bus.nn_class = 8'h11;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("t6_in_ready_low", bus.in_ready, 1'b0);
      checkOutput("t6_class_stable", bus.class_out, 8'd7);
      checkOutput("t6_valid_held", bus.result_valid, 1'b1);
      checkOutput("t6_data_stable", bus.test_data, expData);
    end
    bus.in_valid = 1'b0;
    bus.result_ack = 1'b1;
    @(negedge clk);
    bus.result_ack = 1'b0;
    checkOutput("t6_valid_clr", bus.result_valid, 1'b0);
    checkOutput("t6_in_ready", bus.in_ready, 1'b1);
    checkOutput("t6_cnt_held", bus.frame_cnt, 16'd3);

    $display("[TB] T1 reset mid-WAIT");
    buildExp(10);
    sendFrame(62, 61, 10);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("t1_in_ready", bus.in_ready, 1'b0);
    checkOutput("t1_start", bus.start, 1'b0);
    checkOutput("t1_result_valid", bus.result_valid, 1'b0);
    checkOutput("t1_frame_err", bus.frame_err, 1'b0);
    checkOutput("t1_frame_cnt", bus.frame_cnt, '0);
    checkOutput("t1_test_data", bus.test_data, '0);
    checkOutput("t1_class_out", bus.class_out, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t1_in_ready_after", bus.in_ready, 1'b1);
    buildExp(20);
    sendFrame(62, 61, 20);
    checkOutput("t1_start_after", bus.start, 1'b1);
    checkOutput("t1_test_data_after", bus.test_data, expData);
    finishResult(8'd9, 16'd1);

    $display("[TB] counter wrap on 2-bit instance");
    for (int i = 1; i <= 4; i++) begin
      smallFrame(8'(16 * i), 2'(i));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
